pipe_ctrl_unit: RTL and testbench

Pipeline sequencer for the 5-stage RISC-V core. It owns the global stage enables and the per-stage flush/bubble controls. It merges the taken-branch/jump flush from the branch control unit with the load-use stall from hazard detection, and runs the debug-driven run/step/stop/halt state machine. On a halt instruction it drains the pipeline before reporting halted.

---
 rtl/pipe_ctrl_unit_pkg.sv | 36 +++
 rtl/pipe_ctrl_unit_sat_counter.sv | 34 +++
 rtl/pipe_ctrl_unit.sv | 192 +++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_unit_pkg.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit_pkg
//
// Shared definitions for the pipeline sequencer of the 5-stage RISC-V core.
//
// Contents:
//   pipe_state_t    sequencer state encodings (IDLE=0, RUN=1, STEP=2,
//                   DRAIN=3, DONE=4), 3 bits wide
//   PC_SRC_*        next-PC select codes shared with the branch control unit
//   DRAIN_CNT_W     width of the inline drain counter (covers 1..15 cycles)
//   is_advancing()  true for the states in which the pipeline moves forward
// -----------------------------------------------------------------------------
package pipe_ctrl_unit_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_STEP  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } pipe_state_t;

    // Next-PC select codes, kept in step with the branch control unit
    localparam logic [1:0] PC_SRC_PLUS4   = 2'b00;
    localparam logic [1:0] PC_SRC_IMM     = 2'b01;
    localparam logic [1:0] PC_SRC_RS1_IMM = 2'b10;

    // DRAIN_CYCLES is at most 15, so the drain counter fits in 4 bits
    localparam int DRAIN_CNT_W = 4;

    // States in which ID/EX, EX/MEM, MEM/WB and architectural writes are enabled
    function automatic logic is_advancing(input pipe_state_t s);
        return (s == ST_RUN) || (s == ST_STEP) || (s == ST_DRAIN);
    endfunction

endpackage

// File: rtl/pipe_ctrl_unit_sat_counter.sv
// -----------------------------------------------------------------------------
// sat_counter
//
// Saturating up-counter with synchronous clear. Used as the executed-cycle
// counter of pipe_ctrl_unit. Once all ones, the count holds rather than wrapping.
//
// Parameters:
//   W       counter width
//
// Ports:
//   clk     in   clock
//   clear   in   synchronous clear, takes priority over enable
//   enable  in   count one when high
//   count   out  current count, W bits
// -----------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clear,
    input  logic         enable,
    output logic [W-1:0] count
);

    // Clear wins; otherwise step up until every bit is set, then hold
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// pipe_ctrl_unit
//
// Pipeline sequencer for the 5-stage RISC-V core. It owns the global stage
// enables and the per-stage flush/bubble controls. It merges the taken
// branch/jump flush with the load-use stall and runs the debug
// run/step/stop/halt state machine. A halt instruction drains the pipeline
// for DRAIN_CYCLES cycles before o_halted is reported.
//
// Configuration macro:
//   CYCLE_COUNTER_EN  when defined, o_cycle_count counts cycles with
//                     o_pipe_en high (saturating). When undefined,
//                     o_cycle_count is tied to zero and no counter flops exist.
//
// Parameters:
//   DRAIN_CYCLES  cycles the pipeline keeps advancing after a halt (1..15)
//   CNT_W         width of the executed-cycle counter
//
// Ports:
//   i_clk          in   core clock
//   i_rst_n        in   synchronous active-low reset
//   i_flush        in   taken branch/JAL/JALR this cycle
//   i_stall        in   load-use hazard in ID
//   i_halt         in   halt instruction decoded in ID
//   i_dbg_run      in   debug free-run command
//   i_dbg_step     in   debug single-step command
//   i_dbg_stop     in   debug freeze command
//   o_pc_en        out  PC register load enable
//   o_ifid_en      out  IF/ID register enable
//   o_ifid_flush   out  clear IF/ID to NOP
//   o_idex_flush   out  clear ID/EX to NOP (bubble)
//   o_pipe_en      out  enable for later stage registers and arch writes
//   o_halted       out  high once the halt drain has finished
//   o_step_done    out  one-cycle pulse after a single step completes
//   o_cycle_count  out  number of cycles with o_pipe_en high
// -----------------------------------------------------------------------------
module pipe_ctrl_unit
    import pipe_ctrl_unit_pkg::*;
#(
    parameter int DRAIN_CYCLES = 4,
    parameter int CNT_W        = 32
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_flush,
    input  logic             i_stall,
    input  logic             i_halt,
    input  logic             i_dbg_run,
    input  logic             i_dbg_step,
    input  logic             i_dbg_stop,
    output logic             o_pc_en,
    output logic             o_ifid_en,
    output logic             o_ifid_flush,
    output logic             o_idex_flush,
    output logic             o_pipe_en,
    output logic             o_halted,
    output logic             o_step_done,
    output logic [CNT_W-1:0] o_cycle_count
);

    // The drain counter starts one below the cycle count so that reaching
    // zero marks the last drain cycle
    localparam logic [DRAIN_CNT_W-1:0] DRAIN_LOAD = DRAIN_CNT_W'(DRAIN_CYCLES - 1);

    pipe_state_t            state;
    pipe_state_t            next_state;
    logic [DRAIN_CNT_W-1:0] drain_cnt;
    logic                   step_done_next;
    logic                   halt_accept;
    logic                   enter_drain;

    // A halt only counts when it is on the correct path (no flush) and has
    // actually left ID (no stall); otherwise it is dropped or retried
    assign halt_accept = i_halt && !i_stall && !i_flush &&
                         ((state == ST_RUN) || (state == ST_STEP));

    assign enter_drain = (state != ST_DRAIN) && (next_state == ST_DRAIN);

    // State register and the registered step-completion pulse
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ST_IDLE;
            o_step_done <= 1'b0;
        end else begin
            state       <= next_state;
            o_step_done <= step_done_next;
        end
    end

    // Drain counter: loaded on the way into DRAIN, counts down while there
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            drain_cnt <= '0;
        end else if (enter_drain) begin
            drain_cnt <= DRAIN_LOAD;
        end else if ((state == ST_DRAIN) && (drain_cnt != '0)) begin
            drain_cnt <= drain_cnt - DRAIN_CNT_W'(1);
        end
    end

    // Next-state logic for the debug run/step/stop/halt sequencer
    always_comb begin
        next_state     = state;
        step_done_next = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i_dbg_run) begin
                    next_state = ST_RUN;
                end else if (i_dbg_step) begin
                    next_state = ST_STEP;
                end
            end
            ST_RUN: begin
                // Stop freezes from the next cycle; this cycle still executes
                if (i_dbg_stop) begin
                    next_state = ST_IDLE;
                end else if (halt_accept) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_STEP: begin
                if (halt_accept) begin
                    next_state = ST_DRAIN;
                end else begin
                    next_state     = ST_IDLE;
                    step_done_next = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                next_state = ST_DONE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    // Zero-latency enable and flush outputs. Flush beats stall because the
    // stalled instruction is on the wrong path anyway. During drain only
    // bubbles enter IF/ID while the older instructions run to completion.
    always_comb begin
        o_pc_en      = 1'b0;
        o_ifid_en    = 1'b0;
        o_ifid_flush = 1'b0;
        o_idex_flush = 1'b0;
        unique case (state)
            ST_RUN, ST_STEP: begin
                if (i_flush) begin
                    o_pc_en      = 1'b1;
                    o_ifid_en    = 1'b1;
                    o_ifid_flush = 1'b1;
                    o_idex_flush = 1'b1;
                end else if (i_stall) begin
                    o_idex_flush = 1'b1;
                end else begin
                    o_pc_en   = 1'b1;
                    o_ifid_en = 1'b1;
                end
            end
            ST_DRAIN: begin
                o_ifid_en    = 1'b1;
                o_ifid_flush = 1'b1;
            end
            default: begin
                o_pc_en      = 1'b0;
            end
        endcase
    end

    assign o_pipe_en = is_advancing(state);
    assign o_halted  = (state == ST_DONE);

`ifdef CYCLE_COUNTER_EN
    // Executed-cycle counter, cleared by reset
    sat_counter #(
        .W      (CNT_W)
    ) u_cycle_counter (
        .clk    (i_clk),
        .clear  (!i_rst_n),
        .enable (o_pipe_en),
        .count  (o_cycle_count)
    );
`else
    assign o_cycle_count = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// -----------------------------------------------------------------------------
// tb_pipe_ctrl_unit
//
// Directed self-checking bench for pipe_ctrl_unit with DRAIN_CYCLES=4 and
// CNT_W=32. Inputs change just after the falling edge and outputs are checked
// shortly afterwards, well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_pipe_ctrl_unit;

    localparam int DRAIN_CYCLES = 4;
    localparam int CNT_W        = 32;

    logic             i_clk;
    logic             i_rst_n;
    logic             i_flush;
    logic             i_stall;
    logic             i_halt;
    logic             i_dbg_run;
    logic             i_dbg_step;
    logic             i_dbg_stop;
    logic             o_pc_en;
    logic             o_ifid_en;
    logic             o_ifid_flush;
    logic             o_idex_flush;
    logic             o_pipe_en;
    logic             o_halted;
    logic             o_step_done;
    logic [CNT_W-1:0] o_cycle_count;

    int tests_run;
    int tests_failed;

    pipe_ctrl_unit #(
        .DRAIN_CYCLES  (DRAIN_CYCLES),
        .CNT_W         (CNT_W)
    ) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_flush       (i_flush),
        .i_stall       (i_stall),
        .i_halt        (i_halt),
        .i_dbg_run     (i_dbg_run),
        .i_dbg_step    (i_dbg_step),
        .i_dbg_stop    (i_dbg_stop),
        .o_pc_en       (o_pc_en),
        .o_ifid_en     (o_ifid_en),
        .o_ifid_flush  (o_ifid_flush),
        .o_idex_flush  (o_idex_flush),
        .o_pipe_en     (o_pipe_en),
        .o_halted      (o_halted),
        .o_step_done   (o_step_done),
        .o_cycle_count (o_cycle_count)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Compare one observed value against its hand-computed expectation
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        tests_run++;
        if (observed !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Move to the next falling edge, then drive the input vector for this cycle
    task automatic applyStimulus(input logic rst_n, input logic flush,
                                 input logic stall, input logic halt,
                                 input logic run, input logic step,
                                 input logic stop);
        @(negedge i_clk);
        i_rst_n    = rst_n;
        i_flush    = flush;
        i_stall    = stall;
        i_halt     = halt;
        i_dbg_run  = run;
        i_dbg_step = step;
        i_dbg_stop = stop;
        #1;
    endtask

    // Check the four enable/flush outputs at once: {pc_en, ifid_en, ifid_flush, idex_flush}
    task automatic checkControls(input string tag, input logic [3:0] expected);
        checkOutput(tag, {28'd0, o_pc_en, o_ifid_en, o_ifid_flush, o_idex_flush},
                    {28'd0, expected});
    endtask

    logic [31:0] exp_count5;

    initial begin
        tests_run    = 0;
        tests_failed = 0;
`ifdef CYCLE_COUNTER_EN
        exp_count5 = 32'd5;
`else
        exp_count5 = 32'd0;
`endif
        i_rst_n    = 1'b0;
        i_flush    = 1'b0;
        i_stall    = 1'b0;
        i_halt     = 1'b0;
        i_dbg_run  = 1'b0;
        i_dbg_step = 1'b0;
        i_dbg_stop = 1'b0;

        // Reset state, a run command held during reset must be ignored
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b0, 0, 0, 0, 1, 0, 0);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        checkControls("reset_ctrl", 4'b0000);
        checkOutput("reset_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        checkOutput("reset_halted", {31'd0, o_halted}, 32'd0);
        checkOutput("reset_step_done", {31'd0, o_step_done}, 32'd0);
        checkOutput("reset_count", o_cycle_count, 32'd0);

        // Run command in IDLE: still idle this cycle, RUN the next
        applyStimulus(1'b1, 0, 0, 0, 1, 0, 0);
        checkOutput("idle_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkControls("run_ctrl", 4'b1100);
        checkOutput("run_pipe_en", {31'd0, o_pipe_en}, 32'd1);
        repeat (4) applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("run_count5", o_cycle_count, exp_count5);

        // Flush and stall together: flush wins
        applyStimulus(1'b1, 1, 1, 0, 0, 0, 0);
        checkControls("flush_stall_ctrl", 4'b1111);

        // Two stall cycles (second one carries a halt that must not be accepted)
        applyStimulus(1'b1, 0, 1, 0, 0, 0, 0);
        checkControls("stall1_ctrl", 4'b0001);
        applyStimulus(1'b1, 0, 1, 1, 0, 0, 0);
        checkControls("stall2_ctrl", 4'b0001);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkControls("after_stall_ctrl", 4'b1100);

        // Halt on the wrong path is discarded: still RUN next cycle
        applyStimulus(1'b1, 1, 0, 1, 0, 0, 0);
        checkControls("halt_flush_ctrl", 4'b1111);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkControls("halt_discard_ctrl", 4'b1100);
        checkOutput("halt_discard_halted", {31'd0, o_halted}, 32'd0);

        // Stop: current cycle executes, IDLE afterwards
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 1);
        checkOutput("stop_cycle_pipe_en", {31'd0, o_pipe_en}, 32'd1);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("stopped_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        checkControls("stopped_ctrl", 4'b0000);

        // Single step at t: enabled at t+1, step_done at t+2
        applyStimulus(1'b1, 0, 0, 0, 0, 1, 0);
        checkOutput("step_t_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("step_t1_pipe_en", {31'd0, o_pipe_en}, 32'd1);
        checkOutput("step_t1_done", {31'd0, o_step_done}, 32'd0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("step_t2_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        checkOutput("step_t2_done", {31'd0, o_step_done}, 32'd1);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("step_t3_done", {31'd0, o_step_done}, 32'd0);

        // Reset during STEP: back to IDLE with no step_done pulse
        applyStimulus(1'b1, 0, 0, 0, 0, 1, 0);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_step_pipe_en", {31'd0, o_pipe_en}, 32'd1);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_step_done_a", {31'd0, o_step_done}, 32'd0);
        checkOutput("rst_step_idle", {31'd0, o_pipe_en}, 32'd0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_step_done_b", {31'd0, o_step_done}, 32'd0);

        // Halt in RUN at t: DRAIN for t+1..t+4 ignoring flush/stall/debug, DONE at t+5
        applyStimulus(1'b1, 0, 0, 0, 1, 0, 0);
        applyStimulus(1'b1, 0, 0, 1, 0, 0, 0);
        checkControls("halt_t_ctrl", 4'b1100);
        for (int k = 1; k <= DRAIN_CYCLES; k++) begin
            applyStimulus(1'b1, k[0], ~k[0], 0, 1, 0, 1);
            checkControls($sformatf("drain%0d_ctrl", k), 4'b0110);
            checkOutput($sformatf("drain%0d_pipe_en", k), {31'd0, o_pipe_en}, 32'd1);
            checkOutput($sformatf("drain%0d_halted", k), {31'd0, o_halted}, 32'd0);
        end
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("done_halted", {31'd0, o_halted}, 32'd1);
        checkOutput("done_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        checkControls("done_ctrl", 4'b0000);
        applyStimulus(1'b1, 0, 0, 0, 1, 1, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("done_sticky_halted", {31'd0, o_halted}, 32'd1);
        checkOutput("done_sticky_pipe_en", {31'd0, o_pipe_en}, 32'd0);

        // Reset out of DONE, then reset in the middle of DRAIN
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 1, 0, 0);
        checkOutput("rst_done_halted", {31'd0, o_halted}, 32'd0);
        applyStimulus(1'b1, 0, 0, 1, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkControls("rst_drain_pre_ctrl", 4'b0110);
        applyStimulus(1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkControls("rst_drain_ctrl", 4'b0000);
        checkOutput("rst_drain_pipe_en", {31'd0, o_pipe_en}, 32'd0);
        checkOutput("rst_drain_halted", {31'd0, o_halted}, 32'd0);
        checkOutput("rst_drain_count", o_cycle_count, 32'd0);
        repeat (DRAIN_CYCLES + 1) applyStimulus(1'b1, 0, 0, 0, 0, 0, 0);
        checkOutput("rst_drain_stays_idle", {31'd0, o_halted}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
